// File: rtl/pill_interval_timer_if.sv
// pill_interval_timer_if: button/ROM inputs and mode/countdown outputs of the pill interval timer
interface pill_interval_timer_if;
    logic        setButton;
    logic        loadButton;
    logic        startButton;
    logic [27:0] romContent;
    logic [3:0]  state;
    logic [11:0] pill12And3Duration;
    logic [2:0]  alarm;
    logic        unitTick;
    modport master (
        output setButton, loadButton, startButton, romContent,
        input  state, pill12And3Duration, alarm, unitTick
    );
    modport slave (
        input  setButton, loadButton, startButton, romContent,
        output state, pill12And3Duration, alarm, unitTick
    );
endinterface

// File: rtl/pill_interval_timer.sv
// pill_interval_timer: idle/set/load/run mode FSM with per-pill countdowns, alarms and unit time base
module pill_interval_timer #(
    parameter int TICKS_PER_UNIT = 50000000,
    parameter int PRESCALE_W     = 26
) (
    input logic                  clk,
    input logic                  reset,
    pill_interval_timer_if.slave bus
);
    typedef enum logic [3:0] {IDLE = 4'd0, SET = 4'd1, LOAD = 4'd2, RUN = 4'd3} state_t;
    state_t                r_state, w_next;
    logic                  r_set_q, r_load_q, r_start_q;
    logic                  w_set_e, w_load_e, w_start_e, w_tick, w_latch;
    logic [PRESCALE_W-1:0] r_pre;
    // index 0 is pill1, so the packed array lines up with the output nibbles
    logic [0:2][3:0]       r_int, r_dur, w_dur, w_rom;
    assign w_set_e   = bus.setButton & ~r_set_q;
    assign w_load_e  = bus.loadButton & ~r_load_q;
    assign w_start_e = bus.startButton & ~r_start_q;
    assign w_rom     = {bus.romContent[19:16], bus.romContent[11:8], bus.romContent[3:0]};
    assign w_tick    = (r_state == RUN) && (r_pre == PRESCALE_W'(TICKS_PER_UNIT - 1));
    assign w_latch   = w_load_e && (w_next == LOAD);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_set_e ? SET : IDLE;
            SET:     w_next = w_load_e ? LOAD : SET;
            LOAD:    w_next = w_set_e ? SET : w_load_e ? LOAD : w_start_e ? RUN : LOAD;
            RUN:     w_next = w_set_e ? SET : RUN;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        w_dur     = r_dur;
        bus.alarm = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_next == IDLE || w_next == SET)
                w_dur[i] = 4'h1;
            else if (w_latch)
                w_dur[i] = (w_rom[i] == 4'h0) ? 4'h1 : w_rom[i];
            else if (w_tick)
                w_dur[i] = (r_int[i] == 4'h0) ? 4'h1 : (r_dur[i] == 4'h0) ? r_int[i] : r_dur[i] - 4'h1;
            bus.alarm[i] = (r_state == RUN) && (r_dur[i] == 4'h0);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_set_q   <= 1'b0;
            r_load_q  <= 1'b0;
            r_start_q <= 1'b0;
            r_pre     <= '0;
            r_int     <= '0;
            r_dur     <= 12'h111;
        end else begin
            r_state   <= w_next;
            r_set_q   <= bus.setButton;
            r_load_q  <= bus.loadButton;
            r_start_q <= bus.startButton;
            r_pre     <= (r_state == RUN && w_next == RUN && !w_tick) ? r_pre + 1'b1 : '0;
            r_dur     <= w_dur;
            if (w_latch)
                r_int <= w_rom;
        end
    end
    assign bus.state              = r_state;
    assign bus.pill12And3Duration = r_dur;
    assign bus.unitTick           = w_tick;
endmodule

// File: tb/tb_pill_interval_timer.sv
// tb_pill_interval_timer: table-driven vectors plus directed corner sequences for pill_interval_timer
module tb_pill_interval_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    pill_interval_timer_if bus ();
    pill_interval_timer #(.TICKS_PER_UNIT(4), .PRESCALE_W(3)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        s, l, st;
        logic [27:0] rom;
        int          n;
        logic [3:0]  e_state;
        logic [11:0] e_dur;
        logic [2:0]  e_al;
        logic        e_tick;
    } vec_t;
    localparam logic [27:0] ROM_A = 28'h0030201;
    localparam logic [27:0] ROM_B = 28'h0030001;
    vec_t v [17];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask
    task automatic drive(input logic s, input logic l, input logic st, input logic [27:0] rom);
        bus.setButton   = s;
        bus.loadButton  = l;
        bus.startButton = st;
        bus.romContent  = rom;
    endtask
    initial begin
        int al0_cnt;
        v[0]  = '{1'b1, 1'b0, 1'b0, ROM_A, 1, 4'd1, 12'h111, 3'b000, 1'b0};
        v[1]  = '{1'b0, 1'b1, 1'b0, ROM_A, 1, 4'd2, 12'h321, 3'b000, 1'b0};
        v[2]  = '{1'b0, 1'b0, 1'b1, ROM_A, 1, 4'd3, 12'h321, 3'b000, 1'b0};
        v[3]  = '{1'b0, 1'b0, 1'b0, ROM_A, 3, 4'd3, 12'h321, 3'b000, 1'b1};
        v[4]  = '{1'b0, 1'b0, 1'b0, ROM_A, 1, 4'd3, 12'h210, 3'b100, 1'b0};
        v[5]  = '{1'b0, 1'b0, 1'b0, ROM_A, 3, 4'd3, 12'h210, 3'b100, 1'b1};
        v[6]  = '{1'b0, 1'b0, 1'b0, ROM_A, 1, 4'd3, 12'h101, 3'b010, 1'b0};
        v[7]  = '{1'b0, 1'b0, 1'b0, ROM_A, 3, 4'd3, 12'h101, 3'b010, 1'b1};
        v[8]  = '{1'b0, 1'b0, 1'b0, ROM_A, 1, 4'd3, 12'h020, 3'b101, 1'b0};
        v[9]  = '{1'b0, 1'b0, 1'b0, ROM_A, 3, 4'd3, 12'h020, 3'b101, 1'b1};
        v[10] = '{1'b0, 1'b0, 1'b0, ROM_A, 1, 4'd3, 12'h311, 3'b000, 1'b0};
        v[11] = '{1'b1, 1'b0, 1'b0, ROM_A, 1, 4'd1, 12'h111, 3'b000, 1'b0};
        v[12] = '{1'b0, 1'b0, 1'b0, ROM_A, 1, 4'd1, 12'h111, 3'b000, 1'b0};
        v[13] = '{1'b0, 1'b1, 1'b0, ROM_A, 1, 4'd2, 12'h321, 3'b000, 1'b0};
        v[14] = '{1'b0, 1'b0, 1'b0, 28'h0FFFFFF, 1, 4'd2, 12'h321, 3'b000, 1'b0};
        v[15] = '{1'b1, 1'b1, 1'b0, ROM_A, 1, 4'd1, 12'h111, 3'b000, 1'b0};
        v[16] = '{1'b0, 1'b0, 1'b0, 28'h0, 1, 4'd1, 12'h111, 3'b000, 1'b0};
        drive(1'b0, 1'b0, 1'b0, 28'h0);
        step(2);
        chk("reset state", 32'(bus.state), 32'd0);
        chk("reset dur", 32'(bus.pill12And3Duration), 32'h111);
        chk("reset alarm", 32'(bus.alarm), 32'd0);
        chk("reset tick", 32'(bus.unitTick), 32'd0);
        rst = 1'b0;
        step(1);
        chk("idle after reset", 32'(bus.state), 32'd0);
        for (int i = 0; i < 17; i++) begin
            drive(v[i].s, v[i].l, v[i].st, v[i].rom);
            step(v[i].n);
            chk($sformatf("row%0d state", i), 32'(bus.state), 32'(v[i].e_state));
            chk($sformatf("row%0d dur", i), 32'(bus.pill12And3Duration), 32'(v[i].e_dur));
            chk($sformatf("row%0d alarm", i), 32'(bus.alarm), 32'(v[i].e_al));
            chk($sformatf("row%0d tick", i), 32'(bus.unitTick), 32'(v[i].e_tick));
        end
        drive(1'b0, 1'b1, 1'b0, ROM_B);
        step(1);
        chk("disabled load dur", 32'(bus.pill12And3Duration), 32'h311);
        drive(1'b0, 1'b0, 1'b1, ROM_B);
        step(1);
        chk("disabled run state", 32'(bus.state), 32'd3);
        drive(1'b0, 1'b0, 1'b0, ROM_B);
        al0_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            chk("pill2 held at 1", 32'(bus.pill12And3Duration[7:4]), 32'd1);
            chk("pill2 no alarm", 32'(bus.alarm[1]), 32'd0);
            if (bus.alarm[0]) al0_cnt++;
        end
        chk("pill1 alarm cycles", 32'(al0_cnt), 32'd8);
        drive(1'b1, 1'b0, 1'b0, ROM_A);
        step(1);
        chk("hold: set", 32'(bus.state), 32'd1);
        drive(1'b0, 1'b1, 1'b0, ROM_A);
        step(1);
        chk("hold: load", 32'(bus.state), 32'd2);
        drive(1'b0, 1'b0, 1'b1, ROM_A);
        step(1);
        chk("hold: run entry", 32'(bus.state), 32'd3);
        for (int c = 0; c < 19; c++) begin
            step(1);
            chk("hold: stays run", 32'(bus.state), 32'd3);
        end
        drive(1'b0, 1'b0, 1'b0, ROM_A);
        step(1);
        drive(1'b0, 1'b1, 1'b1, ROM_A);
        step(1);
        chk("run start/load ignored", 32'(bus.state), 32'd3);
        drive(1'b1, 1'b0, 1'b0, ROM_A);
        step(1);
        drive(1'b0, 1'b1, 1'b0, ROM_A);
        step(1);
        drive(1'b0, 1'b0, 1'b1, ROM_A);
        step(1);
        drive(1'b0, 1'b0, 1'b0, ROM_A);
        step(4);
        chk("pre-reset dur", 32'(bus.pill12And3Duration), 32'h210);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("async reset state", 32'(bus.state), 32'd0);
        chk("async reset dur", 32'(bus.pill12And3Duration), 32'h111);
        chk("async reset alarm", 32'(bus.alarm), 32'd0);
        step(1);
        chk("post reset idle", 32'(bus.state), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
